obuf_drain: RTL and testbench

Readout stage directly downstream of the 64-entry output buffer RAM that the post-processing unit (ppu) writes. After a tile completes, it reads a programmed number of buffer rows and serialises each 64-bit row (INT4 x 16) into OUT_WIDTH-bit beats on a valid/ready stream toward the host/DMA side. It owns the RAM read port: it generates the read enable and address and absorbs the RAM's 1-cycle read latency with a 2-entry prefetch FIFO, so backpressure never loses data.

---
 rtl/obuf_drain.sv | 202 ++++++++++++++++++++
 tb/tb_obuf_drain.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obuf_drain.sv
// obuf_drain: reads rows from the output buffer RAM and serialises each
// row into OUT_WIDTH-bit beats on a valid/ready stream.
//
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_start, i_len      start pulse and row count (clamped to ARR_DEPTH)
//   o_busy, o_done      busy window and one-cycle completion pulse
//   o_ram_re/addr       RAM read port; i_ram_data one cycle later
//   o_data/valid/last   output stream, i_ready from downstream
module obuf_drain #(
  parameter int VEC_WIDTH = 64,
  parameter int ARR_DEPTH = 64,
  parameter int OUT_WIDTH = 16,
  localparam int AW = $clog2(ARR_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [AW:0]          i_len,
  output logic                 o_busy,
  output logic                 o_ram_re,
  output logic [AW-1:0]        o_ram_addr,
  input  logic [VEC_WIDTH-1:0] i_ram_data,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_done
);

  localparam int BEATS = VEC_WIDTH / OUT_WIDTH;
  localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(ARR_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW:0]          r_len;
  logic [AW:0]          r_issued;
  logic [AW:0]          r_loaded;
  logic                 r_inflight;
  logic [VEC_WIDTH-1:0] r_fifo0;
  logic [VEC_WIDTH-1:0] r_fifo1;
  logic                 r_wp;
  logic                 r_rp;
  logic [1:0]           r_cnt;
  logic [VEC_WIDTH-1:0] r_row;
  logic [IW-1:0]        r_idx;
  logic                 r_ser_v;
  logic                 r_ser_last;

  logic                 w_xfer;
  logic                 w_row_end;
  logic                 w_ser_free;
  logic                 w_load;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_more;
  logic                 w_start_ok;
  logic [2:0]           w_credit;
  logic [AW:0]          w_eff_len;
  logic [VEC_WIDTH-1:0] w_head;
  logic [VEC_WIDTH-1:0] w_load_row;

  assign w_xfer     = r_ser_v & i_ready;
  assign w_row_end  = w_xfer & (r_idx == LAST_IDX);
  assign w_ser_free = ~r_ser_v | w_row_end;

  // The serialiser refills from the FIFO head, or straight from the RAM
  // when the FIFO is empty, so the first beat and every row change
  // happen without a bubble.
  assign w_load = w_ser_free & ((r_cnt != 2'd0) | r_inflight);
  assign w_pop  = w_load & (r_cnt != 2'd0);
  assign w_push = r_inflight & ~(w_load & (r_cnt == 2'd0));

  assign w_head     = r_rp ? r_fifo1 : r_fifo0;
  assign w_load_row = (r_cnt != 2'd0) ? w_head : i_ram_data;

  // In-flight reads count as FIFO entries so a stalled stream can never
  // overflow the two buffered rows.
  assign w_credit = 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_more   = r_issued < r_len;

  assign w_start_ok = i_start & (i_len != '0);
  assign w_eff_len  = (i_len > DEPTH) ? DEPTH : i_len;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy  = 1'b1;
        w_issue = w_more & (w_credit < 3'd2);
        if (w_xfer & o_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_ram_re   = w_issue;
  assign o_ram_addr = w_issue ? r_issued[AW-1:0] : '0;

  assign o_valid = r_ser_v;
  assign o_data  = r_ser_v ? r_row[r_idx*OUT_WIDTH +: OUT_WIDTH] : '0;
  assign o_last  = r_ser_v & r_ser_last & (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_loaded   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_len    <= w_eff_len;
        r_issued <= '0;
        r_loaded <= '0;
      end else begin
        if (w_issue) r_issued <= r_issued + (AW + 1)'(1);
        if (w_load) r_loaded <= r_loaded + (AW + 1)'(1);
      end
      r_inflight <= w_issue;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fifo0 <= '0;
      r_fifo1 <= '0;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wp) r_fifo1 <= i_ram_data;
        else      r_fifo0 <= i_ram_data;
        r_wp <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row      <= '0;
      r_idx      <= '0;
      r_ser_v    <= 1'b0;
      r_ser_last <= 1'b0;
    end else begin
      if (w_load) begin
        r_row      <= w_load_row;
        r_idx      <= '0;
        r_ser_v    <= 1'b1;
        r_ser_last <= (r_loaded == r_len - (AW + 1)'(1));
      end else if (w_row_end) begin
        r_ser_v    <= 1'b0;
        r_ser_last <= 1'b0;
      end else if (w_xfer) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(w_push && !w_pop && (r_cnt == 2'd2)))
        else $error("obuf_drain: prefetch FIFO overflow");
      assert ((3'(r_cnt) + 3'(r_inflight)) <= 3'd2)
        else $error("obuf_drain: prefetch credit exceeded");
    end
  end
`endif

endmodule

// File: tb/tb_obuf_drain.sv
// tb_obuf_drain: directed table plus hand sequences for obuf_drain,
// with a behavioural RAM and negedge stream monitors.
module tb_obuf_drain;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, start64;
  logic [AW:0]   len, len64;
  logic          busy, re, valid, last, done, ready;
  logic [AW-1:0] addr;
  logic [63:0]   rdata;
  logic [15:0]   data;
  logic          busy64, re64, valid64, last64, done64, ready64;
  logic [AW-1:0] addr64;
  logic [63:0]   rdata64, data64;

  obuf_drain #(.VEC_WIDTH(64), .ARR_DEPTH(64), .OUT_WIDTH(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
    .o_busy(busy), .o_ram_re(re), .o_ram_addr(addr),
    .i_ram_data(rdata), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_last(last), .o_done(done));

  obuf_drain #(.VEC_WIDTH(64), .ARR_DEPTH(64), .OUT_WIDTH(64)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_start(start64), .i_len(len64),
    .o_busy(busy64), .o_ram_re(re64), .o_ram_addr(addr64),
    .i_ram_data(rdata64), .o_data(data64), .o_valid(valid64),
    .i_ready(ready64), .o_last(last64), .o_done(done64));

  function automatic logic [63:0] row(input int k);
    logic [3:0] n;
    n = k[3:0];
    return {4{12'h0, n}} + 64'(k);
  endfunction

  function automatic logic [15:0] beat16(input int b);
    logic [63:0] r;
    r = row(b / 4);
    return r[(b % 4)*16 +: 16];
  endfunction

  always @(posedge clk) begin
    if (re) rdata <= row(int'(addr));
    if (re64) rdata64 <= row(int'(addr64));
  end

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic clr = 1'b0;
  int nbeats, nreads, nlast, ndone, nbusy, last_cyc, done_cyc;
  int data_err, addr_err, stab_err, occ_err;
  logic pv_stall;
  logic [15:0] pv_data;
  logic pv_last;
  int nb64, first64, lcyc64, nlast64, derr64, gap64;

  always @(negedge clk) begin
    if (clr) begin
      nbeats <= 0; nreads <= 0; nlast <= 0; ndone <= 0; nbusy <= 0;
      last_cyc <= -1; done_cyc <= -1;
      data_err <= 0; addr_err <= 0; stab_err <= 0; occ_err <= 0;
      pv_stall <= 1'b0; pv_data <= '0; pv_last <= 1'b0;
      nb64 <= 0; first64 <= -1; lcyc64 <= -1; nlast64 <= 0;
      derr64 <= 0; gap64 <= 0;
    end else begin
      if (re) begin
        nreads <= nreads + 1;
        if (int'(addr) != nreads) addr_err <= addr_err + 1;
      end
      if (busy) nbusy <= nbusy + 1;
      if (done) begin
        ndone <= ndone + 1;
        done_cyc <= cyc - t0;
      end
      if (nreads - nbeats / 4 > 3) occ_err <= occ_err + 1;
      if (pv_stall && (!valid || data != pv_data || last != pv_last))
        stab_err <= stab_err + 1;
      pv_stall <= valid && !ready;
      pv_data <= data;
      pv_last <= last;
      if (valid && ready) begin
        if (data != beat16(nbeats)) data_err <= data_err + 1;
        if (last) begin
          nlast <= nlast + 1;
          last_cyc <= cyc - t0;
        end
        nbeats <= nbeats + 1;
      end
      if (valid64 && ready64) begin
        if (data64 != row(nb64)) derr64 <= derr64 + 1;
        if (nb64 == 0) first64 <= cyc - t0;
        else if (cyc - t0 != first64 + nb64) gap64 <= gap64 + 1;
        if (last64) begin
          nlast64 <= nlast64 + 1;
          lcyc64 <= cyc - t0;
        end
        nb64 <= nb64 + 1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  task automatic start_drain(input int l);
    @(posedge clk); #1;
    start = 1'b1;
    len = l[AW:0];
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int stall_reads;

  // mode 0: ready high, 1: random ready, 2: ready low 20 cycles after
  // the first valid beat
  task automatic wait_done(input string name, input int budget,
                           input int mode);
    int n;
    int held;
    bit seen;
    n = 0; held = 0; seen = 0;
    while (n < budget && ndone == 0) begin
      @(posedge clk); #1;
      n++;
      if (mode == 1) ready = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (valid) seen = 1;
        if (seen) held++;
        if (held == 20) stall_reads = nreads;
        ready = (held > 20);
      end
    end
    total++;
    if (ndone == 0) begin
      bad++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    int len;
    int beats;
    int reads;
    int last_cyc;
    int done_cyc;
    int busy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{4, 16, 4, 18, 19, 19};
    tbl[1] = '{1, 4, 1, 6, 7, 7};
    tbl[2] = '{2, 8, 2, 10, 11, 11};
    tbl[3] = '{0, 0, 0, -1, -1, 0};
    tbl[4] = '{100, 256, 64, 258, 259, 259};
    tbl[5] = '{64, 256, 64, 258, 259, 259};

    void'($urandom(32'd1234));
    rst = 1'b1; start = 1'b0; start64 = 1'b0;
    len = '0; len64 = '0; ready = 1'b1; ready64 = 1'b1;
    #1;
    chk("reset_out16",
        int'({busy, re, addr, valid, data, last, done}), 0);
    chk("reset_out64",
        int'({busy64, re64, addr64, valid64, last64, done64}) |
        int'(data64 != 64'd0), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_clr();
      start_drain(tbl[i].len);
      if (tbl[i].len != 0) wait_done($sformatf("v%0d", i), 400, 0);
      else repeat (10) @(posedge clk);
      chk($sformatf("v%0d_beats", i), nbeats, tbl[i].beats);
      chk($sformatf("v%0d_reads", i), nreads, tbl[i].reads);
      chk($sformatf("v%0d_nlast", i), nlast, tbl[i].beats != 0 ? 1 : 0);
      chk($sformatf("v%0d_last_cyc", i), last_cyc, tbl[i].last_cyc);
      chk($sformatf("v%0d_done_cyc", i), done_cyc, tbl[i].done_cyc);
      chk($sformatf("v%0d_busy", i), nbusy, tbl[i].busy);
      chk($sformatf("v%0d_data", i), data_err, 0);
      chk($sformatf("v%0d_addr", i), addr_err, 0);
    end

    // random backpressure
    do_clr();
    start_drain(8);
    wait_done("rnd", 600, 1);
    chk("rnd_beats", nbeats, 32);
    chk("rnd_reads", nreads, 8);
    chk("rnd_data", data_err, 0);
    chk("rnd_stable", stab_err, 0);
    chk("rnd_occ", occ_err, 0);
    chk("rnd_nlast", nlast, 1);
    chk("rnd_ndone", ndone, 1);

    // start re-pulsed mid-drain
    do_clr();
    start_drain(4);
    repeat (6) @(posedge clk);
    #1 start = 1'b1; len = 7'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_done("restart", 200, 0);
    chk("restart_beats", nbeats, 16);
    chk("restart_reads", nreads, 4);
    chk("restart_done_cyc", done_cyc, 19);
    chk("restart_ndone", ndone, 1);

    // long stall
    do_clr();
    stall_reads = -1;
    ready = 1'b0;
    start_drain(3);
    wait_done("stall", 200, 2);
    chk("stall_reads_held", stall_reads, 3);
    chk("stall_reads", nreads, 3);
    chk("stall_beats", nbeats, 12);
    chk("stall_data", data_err, 0);
    chk("stall_stable", stab_err, 0);
    chk("stall_nlast", nlast, 1);
    chk("stall_ndone", ndone, 1);

    // reset on the fifth transfer
    do_clr();
    start_drain(4);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (valid && ready && nbeats == 4) break;
    end
    #1 rst = 1'b1;
    #1 chk("rst_async",
           int'({busy, re, addr, valid, data, last, done}), 0);
    @(posedge clk); #1;
    chk("rst_held",
        int'({busy, re, addr, valid, data, last, done}), 0);
    rst = 1'b0;
    do_clr();
    start_drain(1);
    wait_done("post_rst", 100, 0);
    chk("post_rst_beats", nbeats, 4);
    chk("post_rst_reads", nreads, 1);
    chk("post_rst_addr", addr_err, 0);
    chk("post_rst_data", data_err, 0);
    chk("post_rst_last_cyc", last_cyc, 6);
    chk("post_rst_done_cyc", done_cyc, 7);

    // full-width beats, one row per cycle
    do_clr();
    @(posedge clk); #1;
    start64 = 1'b1; len64 = 7'd64; t0 = cyc;
    @(posedge clk); #1 start64 = 1'b0;
    for (int k = 0; k < 200 && !done64; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("w64_beats", nb64, 64);
    chk("w64_first", first64, 3);
    chk("w64_last_cyc", lcyc64, 66);
    chk("w64_nlast", nlast64, 1);
    chk("w64_data", derr64, 0);
    chk("w64_gaps", gap64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
